// File: rtl/stream_scan_ctrl.sv
// stream_scan_ctrl
// Raster sequencer that walks every position of a frame, including blanking.
// In the active region it pulls pixels from a valid/ready source. In blanking
// it inserts zeros. Each position produces exactly one registered enable beat
// toward the patch extractor.
module stream_scan_ctrl #(
   parameter int BIT_WIDTH    = 8,
   parameter int IMAGE_HEIGHT = 480,
   parameter int IMAGE_WIDTH  = 640,
   parameter int FRAME_HEIGHT = 525,
   parameter int FRAME_WIDTH  = 800,
   parameter int V_BITW       = $clog2(FRAME_HEIGHT),
   parameter int H_BITW       = $clog2(FRAME_WIDTH)
) (
   input  logic                 clock,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 cont,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [BIT_WIDTH-1:0] in_pixel,
   input  logic                 out_ready,
   output logic                 enable,
   output logic [BIT_WIDTH-1:0] out_pixel,
   output logic [V_BITW-1:0]    out_vcnt,
   output logic [H_BITW-1:0]    out_hcnt,
   output logic                 busy,
   output logic                 frame_done,
   output logic [15:0]          stall_cycles
);

   // Boundary positions, expressed at counter width so that every compare
   // has matching widths.
   localparam logic [V_BITW-1:0] V_LAST = V_BITW'(FRAME_HEIGHT - 1);
   localparam logic [H_BITW-1:0] H_LAST = H_BITW'(FRAME_WIDTH - 1);
   localparam logic [V_BITW-1:0] V_IMG  = V_BITW'(IMAGE_HEIGHT);
   localparam logic [H_BITW-1:0] H_IMG  = H_BITW'(IMAGE_WIDTH);
   localparam logic [15:0]       STALL_MAX = 16'hFFFF;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t              state_q, state_d;
   logic [V_BITW-1:0]   vpos_q, vpos_d;
   logic [H_BITW-1:0]   hpos_q, hpos_d;
   logic [15:0]         stall_q, stall_d;

   logic                running;
   logic                active;
   logic                starved;
   logic                beat;
   logic                last_pos;

   // Per-cycle qualifiers derived from the current position and handshakes.
   // A beat needs downstream room. In the active region it also needs a
   // source pixel. In blanking the zero pixel is always available.
   assign running  = (state_q == RUN);
   assign active   = (vpos_q < V_IMG) && (hpos_q < H_IMG);
   assign starved  = running && active && out_ready && !in_valid;
   assign beat     = running && out_ready && (!active || in_valid);
   assign last_pos = (vpos_q == V_LAST) && (hpos_q == H_LAST);

   // The source is consumed only when a beat can take its pixel.
   assign in_ready     = running && active && out_ready;
   assign busy         = running;
   assign stall_cycles = stall_q;

   // Next-state logic: start a frame from idle, advance the raster on every
   // beat, count starved cycles, and either restart or stop at frame end.
   always_comb begin
      state_d = state_q;
      vpos_d  = vpos_q;
      hpos_d  = hpos_q;
      stall_d = stall_q;

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = RUN;
               vpos_d  = '0;
               hpos_d  = '0;
               stall_d = '0;
            end
         end

         RUN: begin
            if (starved && (stall_q != STALL_MAX)) begin
               stall_d = stall_q + 16'd1;
            end

            if (beat) begin
               if (hpos_q == H_LAST) begin
                  hpos_d = '0;
                  if (vpos_q == V_LAST) begin
                     vpos_d = '0;
                  end else begin
                     vpos_d = vpos_q + V_BITW'(1);
                  end
               end else begin
                  hpos_d = hpos_q + H_BITW'(1);
               end

               if (last_pos) begin
                  if (cont) begin
                     state_d = RUN;
                     stall_d = '0;
                  end else begin
                     state_d = IDLE;
                  end
               end
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State, raster position and stall counter registers.
   always_ff @(posedge clock) begin
      if (rst) begin
         state_q <= IDLE;
         vpos_q  <= '0;
         hpos_q  <= '0;
         stall_q <= '0;
      end else begin
         state_q <= state_d;
         vpos_q  <= vpos_d;
         hpos_q  <= hpos_d;
         stall_q <= stall_d;
      end
   end

   // Registered beat toward the extractor. Pixel and coordinates hold between
   // beats, so downstream only has to look at enable.
   always_ff @(posedge clock) begin
      if (rst) begin
         enable     <= 1'b0;
         frame_done <= 1'b0;
         out_pixel  <= '0;
         out_vcnt   <= '0;
         out_hcnt   <= '0;
      end else begin
         enable     <= beat;
         frame_done <= beat && last_pos;
         if (beat) begin
            out_pixel <= active ? in_pixel : '0;
            out_vcnt  <= vpos_q;
            out_hcnt  <= hpos_q;
         end
      end
   end

endmodule
